uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmit path (write latch, bit-time generator, TX shift control) among up to `NUM_REQ` byte sources. It accepts one byte at a time from the winning requester and issues a one-cycle write strobe with that byte to the TX path. It then tracks the path's busy indication until the frame completes, and only then arbitrates again. It sits between the application-side byte producers and the existing UART TX datapath.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `START_TIMEOUT`, default 16: maximum number of cycles to wait for `tx_busy` to rise after a strobe.
- `clk_50M`  in  1: system clock, 50 MHz, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req`  in  NUM_REQ: per-requester byte-pending level. Each requester holds it high until its grant.
- `req_data`  in  NUM_REQ*8: byte for requester i on bits [8i+7:8i]. Each requester holds it stable while its `req` bit is high.
- `grant`  out  NUM_REQ: one-hot, one-cycle pulse. It marks the cycle in which requester i's byte was taken.
- `tx_write`  out  1: one-cycle write strobe to the TX path.
- `tx_data`  out  8: byte to the TX path. Valid while `tx_write` is high and held until the next strobe.
- `tx_busy`  in  1: TX path frame-in-progress level (the bit-time generator run flag).
- `active_id`  out  3: index of the last granted requester.
- `idle`  out  1: high when the arbiter is in IDLE.
- `tx_err`  out  1: one-cycle pulse on start timeout.

## Operation
- All outputs are registered.
- Reset values:
  - state = IDLE, `grant` = 0, `tx_write` = 0, `tx_data` = 0x00.
  - `active_id` = NUM_REQ-1, so requester 0 has first priority.
  - `idle` = 1, `tx_err` = 0, timeout counter = 0.
- State machine, three states:
  - IDLE: if `req` != 0 and `tx_busy` = 0, select the winner w. Search starts at `active_id`+1 and wraps modulo NUM_REQ; the first set `req` bit wins. Register `tx_data` = byte w, `tx_write` = 1, `grant[w]` = 1, `active_id` = w, clear the counter, and go to WAIT_BUSY. Otherwise stay in IDLE.
  - WAIT_BUSY: if `tx_busy` = 1, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches START_TIMEOUT, pulse `tx_err` and return to IDLE. The byte is dropped, not retried.
  - WAIT_DONE: stay until `tx_busy` = 0, then go to IDLE.
- Width rules:
  - The counter is wide enough to hold START_TIMEOUT and saturates at it.
  - `active_id` uses the low bits of a 3-bit field; the unused upper values are never produced.
- `req` is ignored outside IDLE. A requester that receives its grant must drop `req` or present its next byte by the following cycle. It is not re-served before IDLE is re-entered.
- Grant order with all requesters continuously requesting is 0,1,…,NUM_REQ-1,0,…. No requester waits more than NUM_REQ-1 other frames.
- `tx_busy` high while in IDLE (for example, a foreign write) blocks arbitration; no grant is issued.
- Reset asserted in any state returns all outputs to their reset values immediately. Any frame the TX path has in progress is not tracked after reset.

## Timing
- Cycle N: IDLE with qualifying `req` and `tx_busy` = 0.
- Cycle N+1: `grant[w]`, `tx_write` and the new `tx_data` are high/valid together, for exactly one cycle each; state = WAIT_BUSY and `idle` = 0.
- `tx_busy` is sampled from cycle N+2 onward. WAIT_DONE is entered one cycle after `tx_busy` is first seen high.
- After `tx_busy` falls in cycle M, `idle` = 1 in cycle M+1. The earliest next strobe is in cycle M+2.
- Timeout case: `tx_err` is high in the cycle after the counter reaches START_TIMEOUT, and `idle` = 1 in that same cycle.
- Minimum spacing between strobes: one full frame plus 3 cycles.

## Test plan
- Single request: `req` = 0001, `req_data[7:0]` = 0x55. Required: `grant` = 0001 and `tx_write` high one cycle later with `tx_data` = 0x55. `uart_txd` shows frame 0x55. `idle` returns high one cycle after `tx_busy` falls.
- All requesters set: `req` = 1111 with bytes 0xA0..0xA3, each requester dropping after its grant. Required: grants in order 0,1,2,3, and transmitted bytes 0xA0, 0xA1, 0xA2, 0xA3.
- Fairness: `req[0]` and `req[2]` held continuously with new bytes after each grant. Required: grants strictly alternate 0,2,0,2 over 8 frames; requesters 1 and 3 receive no grants.
- Start timeout: `tx_busy` tied to 0, `req` = 0010. Required: `tx_err` pulses exactly once, 16 cycles after WAIT_BUSY entry. The arbiter then re-grants requester 2 if it is requesting, else requester 1 again.
- Busy block: `tx_busy` = 1 in IDLE with `req` = 0100. Required: no grant while busy; the grant comes 1 cycle after `tx_busy` falls.
- Reset mid-frame: assert `reset` in WAIT_DONE. Required: `idle` = 1, `grant` = 0, `tx_write` = 0, `tx_data` = 0x00 and `active_id` = 3 asynchronously. After release the first grant goes to requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin front end for a shared UART transmit path.
// Takes one byte at a time from the winning requester, fires a one-cycle
// write strobe into the TX datapath, then follows tx_busy until the frame
// has finished before arbitrating again. A missing busy response within
// START_TIMEOUT cycles drops the byte and raises a one-cycle tx_err.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 16
) (
    input  logic                   clk_50M,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*8-1:0]   req_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   tx_write,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic [2:0]             active_id,
    output logic                   idle,
    output logic                   tx_err
);

    // Counter holds values 0..START_TIMEOUT inclusive.
    localparam int                CNT_W   = $clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(START_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
    // Reset value of active_id so requester 0 is searched first.
    localparam logic [2:0]        LAST_ID = 3'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    // Distance of requester idx from the one after last_id, walking upward
    // and wrapping at NUM_REQ. Smallest distance wins the search.
    function automatic int rank_of(input int idx, input logic [2:0] last_id);
        int last_i;
        last_i = int'(last_id);
        if (idx > last_i) begin
            return idx - last_i - 1;
        end else begin
            return idx + NUM_REQ - last_i - 1;
        end
    endfunction

    state_t                state_r, state_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s, cnt_inc_s;
    logic [NUM_REQ-1:0]    grant_r, grant_s;
    logic                  tx_write_r, tx_write_s;
    logic [7:0]            tx_data_r, tx_data_s;
    logic [2:0]            active_id_r, active_id_s;
    logic                  idle_r, idle_s;
    logic                  tx_err_r, tx_err_s;

    logic                  win_found_s;
    logic [2:0]            win_id_s;
    logic [7:0]            win_byte_s;
    int                    best_rank_s;

    // Round-robin search: pick the pending requester closest after active_id.
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = 3'd0;
        win_byte_s  = 8'h00;
        best_rank_s = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && (rank_of(i, active_id_r) < best_rank_s)) begin
                best_rank_s = rank_of(i, active_id_r);
                win_found_s = 1'b1;
                win_id_s    = 3'(i);
                win_byte_s  = req_data[i*8 +: 8];
            end else begin
                best_rank_s = best_rank_s;
            end
        end
    end

    // Saturating increment of the start-timeout counter.
    always_comb begin
        if (cnt_r == CNT_MAX) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + CNT_ONE;
        end
    end

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        grant_s     = {NUM_REQ{1'b0}};
        tx_write_s  = 1'b0;
        tx_data_s   = tx_data_r;
        active_id_s = active_id_r;
        tx_err_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A busy TX path (e.g. a foreign write) blocks arbitration.
                if (win_found_s && !tx_busy) begin
                    state_s           = ST_WAIT_BUSY;
                    cnt_s             = CNT_ZERO;
                    grant_s[win_id_s] = 1'b1;
                    tx_write_s        = 1'b1;
                    tx_data_s         = win_byte_s;
                    active_id_s       = win_id_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT_BUSY: begin
                // The strobe cycle itself is too early for the TX path to
                // have responded, so busy is only honoured afterwards.
                if (tx_busy && !tx_write_r) begin
                    state_s = ST_WAIT_DONE;
                end else if (cnt_inc_s == CNT_MAX) begin
                    // Byte is dropped; no retry.
                    cnt_s    = cnt_inc_s;
                    tx_err_s = 1'b1;
                    state_s  = ST_IDLE;
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        idle_s = (state_s == ST_IDLE);
    end

    // State, counter and output registers with asynchronous reset.
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            grant_r     <= {NUM_REQ{1'b0}};
            tx_write_r  <= 1'b0;
            tx_data_r   <= 8'h00;
            active_id_r <= LAST_ID;
            idle_r      <= 1'b1;
            tx_err_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            grant_r     <= grant_s;
            tx_write_r  <= tx_write_s;
            tx_data_r   <= tx_data_s;
            active_id_r <= active_id_s;
            idle_r      <= idle_s;
            tx_err_r    <= tx_err_s;
        end
    end

    assign grant     = grant_r;
    assign tx_write  = tx_write_r;
    assign tx_data   = tx_data_r;
    assign active_id = active_id_r;
    assign idle      = idle_r;
    assign tx_err    = tx_err_r;

endmodule
